// File: rtl/rsa_decrypt.sv
// rsa_decrypt: sequential RSA decryption, plaint = cipht^D mod N.
// Right-to-left square-and-multiply over a bit-serial interleaved modular
// multiplier (one scanned operand bit per cycle, 32 cycles per multiply).
// Optional macro RSA_DEC_CONST_TIME_EN: always run the res multiply so the
// latency does not depend on D; otherwise skip it when the exponent bit is 0.
// Handshake: cipht is accepted on any rising edge where in_vaild && ready;
// ready is high only in IDLE; vaild is a one-cycle pulse marking a new plaint.
module rsa_decrypt #(
    parameter logic [31:0] N     = 32'd3233,
    parameter logic [31:0] D     = 32'd2753,
    parameter int          EXP_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_vaild,
    input  logic [31:0] cipht,
    output logic        ready,
    output logic        vaild,
    output logic [31:0] plaint,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REDUCE = 3'd1,
        S_MUL_R  = 3'd2,
        S_MUL_B  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [33:0] N34      = {2'b00, N};
    localparam logic [4:0]  LAST_IDX = 5'(EXP_W - 1);

    state_t      state, state_nx;
    logic [31:0] res, base, scan;
    logic [33:0] acc;
    logic [4:0]  bitcnt, expidx;

    logic [33:0] x_op, t0, t1, acc_nx;
    logic        last_bit;
    logic [4:0]  idx_nxt;
    logic        run_r_first, run_r_next;

    // One interleaved multiply step: t = 2*acc + (b ? x : 0), t < 3N, so at most two subtractions.
    always_comb begin
        x_op     = (state == S_REDUCE) ? 34'd1 : {2'b00, base};
        t0       = (acc << 1) + (scan[31] ? x_op : 34'd0);
        t1       = (t0 >= N34) ? (t0 - N34) : t0;
        acc_nx   = (t1 >= N34) ? (t1 - N34) : t1;
        last_bit = (bitcnt == 5'd31);
        idx_nxt  = expidx + 5'd1;
`ifdef RSA_DEC_CONST_TIME_EN
        run_r_first = 1'b1;
        run_r_next  = 1'b1;
`else
        run_r_first = D[0];
        run_r_next  = D[idx_nxt];
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nx  = state;
        ready     = 1'b0;
        vaild     = 1'b0;
        dbg_state = state;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (in_vaild) state_nx = S_REDUCE;
            end
            S_REDUCE: if (last_bit) state_nx = run_r_first ? S_MUL_R : S_MUL_B;
            S_MUL_R:  if (last_bit) state_nx = S_MUL_B;
            S_MUL_B: begin
                if (last_bit) begin
                    if (expidx == LAST_IDX) state_nx = S_DONE;
                    else                    state_nx = run_r_next ? S_MUL_R : S_MUL_B;
                end
            end
            S_DONE:  begin
                vaild    = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: multiply steps, write-back at the end of each multiply, and operand setup for the next.
    always_ff @(posedge clk) begin
        if (reset) begin
            res    <= 32'd0;
            base   <= 32'd0;
            acc    <= 34'd0;
            bitcnt <= 5'd0;
            expidx <= 5'd0;
            scan   <= 32'd0;
            plaint <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_vaild) begin
                        scan   <= cipht;
                        acc    <= 34'd0;
                        bitcnt <= 5'd0;
                    end
                end
                S_REDUCE, S_MUL_R, S_MUL_B: begin
                    acc    <= acc_nx;
                    scan   <= scan << 1;
                    bitcnt <= bitcnt + 5'd1;
                    if (last_bit) begin
                        acc <= 34'd0;
                        if (state == S_REDUCE) begin
                            base   <= acc_nx[31:0];
                            res    <= 32'd1;
                            expidx <= 5'd0;
                            scan   <= run_r_first ? 32'd1 : acc_nx[31:0];
                        end else if (state == S_MUL_R) begin
`ifdef RSA_DEC_CONST_TIME_EN
                            if (D[expidx]) res <= acc_nx[31:0];
`else
                            res <= acc_nx[31:0];
`endif
                            scan <= base;
                        end else begin
                            base <= acc_nx[31:0];
                            if (expidx == LAST_IDX) begin
                                plaint <= res;
                            end else begin
                                expidx <= idx_nxt;
                                scan   <= run_r_next ? res : acc_nx[31:0];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_decrypt.sv
// tb_rsa_decrypt: directed vectors for rsa_decrypt with defaults N=3233, D=2753, EXP_W=12.
module tb_rsa_decrypt;

`ifdef RSA_DEC_CONST_TIME_EN
    localparam int L = 800;   // 32 + 64*12
`else
    localparam int L = 576;   // 32 + 32*12 + 32*popcount(2753)=5
`endif
    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_vaild;
    logic [31:0] cipht;
    logic        ready;
    logic        vaild;
    logic [31:0] plaint;
    logic [2:0]  dbg_state;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    rsa_decrypt dut (
        .clk       (clk),
        .reset     (reset),
        .in_vaild  (in_vaild),
        .cipht     (cipht),
        .ready     (ready),
        .vaild     (vaild),
        .plaint    (plaint),
        .dbg_state (dbg_state)
    );

    // Clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the DONE cycle.
    task automatic run_dec(input string tag, input logic [31:0] c, input logic [31:0] exp_p,
                           input bit spam, output int vcyc);
        int lat;
        bit ready_low;
        check({tag, " ready_before"}, {31'd0, ready}, 32'd1);
        in_vaild = 1'b1;
        cipht    = c;
        @(posedge clk);
        #1;
        if (spam) cipht = 32'd100;
        else begin
            in_vaild = 1'b0;
            cipht    = 32'd0;
        end
        lat = 0;
        ready_low = 1'b1;
        vcyc = 0;
        for (int i = 1; i <= LIMIT; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (vaild) begin
                lat  = i;
                vcyc = cyc;
                break;
            end
            if (ready) ready_low = 1'b0;
        end
        in_vaild = 1'b0;
        cipht    = 32'd0;
        check({tag, " latency"}, lat, L);
        check({tag, " plaint"}, plaint, exp_p);
        check({tag, " ready_in_done"}, {31'd0, ready}, 32'd0);
        if (spam) check({tag, " ready_low_throughout"}, {31'd0, ready_low}, 32'd1);
        @(negedge clk);
        check({tag, " vaild_one_cycle"}, {31'd0, vaild}, 32'd0);
        check({tag, " ready_back"}, {31'd0, ready}, 32'd1);
        check({tag, " plaint_held"}, plaint, exp_p);
    endtask

    initial begin
        int v1, v2, vdummy;
        bit saw_v;

        reset    = 1'b1;
        in_vaild = 1'b0;
        cipht    = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", {31'd0, ready}, 32'd1);
        check("reset vaild", {31'd0, vaild}, 32'd0);
        check("reset plaint", plaint, 32'd0);
        reset = 1'b0;

        // Main function and edge values.
        run_dec("c2790", 32'd2790, 32'd65, 1'b0, vdummy);
        run_dec("c6023", 32'd6023, 32'd65, 1'b0, vdummy);
        run_dec("c0", 32'd0, 32'd0, 1'b0, vdummy);
        run_dec("c1", 32'd1, 32'd1, 1'b0, vdummy);
        run_dec("c3232", 32'd3232, 32'd3232, 1'b0, vdummy);

        // in_vaild held high with cipht=100 during a decryption must be ignored.
        run_dec("spam", 32'd2790, 32'd65, 1'b1, vdummy);
        saw_v = 1'b0;
        repeat (700) begin
            @(negedge clk);
            if (vaild) saw_v = 1'b1;
        end
        check("spam no_extra_vaild", {31'd0, saw_v}, 32'd0);

        // Reset mid-operation at accept+300.
        in_vaild = 1'b1;
        cipht    = 32'd2790;
        @(posedge clk);
        #1;
        in_vaild = 1'b0;
        cipht    = 32'd0;
        repeat (299) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset ready", {31'd0, ready}, 32'd1);
        check("midreset vaild", {31'd0, vaild}, 32'd0);
        check("midreset plaint", plaint, 32'd0);
        saw_v = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (vaild) saw_v = 1'b1;
        end
        check("midreset no_vaild", {31'd0, saw_v}, 32'd0);
        run_dec("after_reset", 32'd2790, 32'd65, 1'b0, vdummy);

        // Back-to-back: second accept on the first cycle ready is high again.
        run_dec("b2b_first", 32'd2790, 32'd65, 1'b0, v1);
        run_dec("b2b_second", 32'd1, 32'd1, 1'b0, v2);
        check("b2b spacing", v2 - v1, L + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_decrypt.md
# rsa_decrypt

Sequential RSA decryption core: computes plaint = cipht^D mod N for a 32-bit ciphertext using right-to-left square-and-multiply over a bit-serial interleaved modular multiplier. It is the receive-side counterpart of `RSA_top` and shares the same handshake signal names: `in_vaild`/`ready` in, `vaild` out. The private exponent and modulus are fixed at elaboration.

## Interface
- N, 32'd3233: modulus; must satisfy 1 < N < 2^32.
- D, 32'd2753: private exponent; only bits [EXP_W-1:0] are used.
- EXP_W, 12: number of exponent bits processed; range 1..32.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_vaild  in  1  input strobe; `cipht` is accepted on any edge where `in_vaild && ready`.
- cipht  in  32  ciphertext; any 32-bit value, including values ≥ N.
- ready  out  1  high only in IDLE.
- vaild  out  1  one-cycle pulse marking a new `plaint`.
- plaint  out  32  decrypted result, always < N; held until the next result or reset.

## Operation
- Datapath registers:
  - `res` (32 bits)
  - `base` (32 bits)
  - `acc` (34 bits)
  - `bitcnt` (5 bits)
  - `expidx` (5 bits)
  - `scan` (32-bit shift register for the scanned operand)
- Modular multiply step, acc × x mod N, with x < N and one scanned bit b per cycle (MSB first):
  - t = 2·acc + (b ? x : 0), computed in 34 bits.
  - Because t < 3N, subtract N at most twice to reach acc' < N.
  - Each multiply takes exactly 32 cycles.
- State machine and transitions:
  - IDLE: `ready`=1. On accept, latch `cipht` into `scan`, clear `acc`, and go to REDUCE.
  - REDUCE: multiplies `cipht` × 1 for 32 cycles, which yields cipht mod N. Then set base ← acc, res ← 1, expidx ← 0, and go to MUL_R.
  - MUL_R: computes res ← res × base mod N, where `scan`=res and x=base. Then go to MUL_B.
  - MUL_B: computes base ← base × base mod N.
    - If expidx == EXP_W-1: go to DONE and register plaint ← res.
    - Otherwise: increment expidx and go to MUL_R.
  - DONE: `vaild`=1 for exactly one cycle, `ready`=0, then go to IDLE.
- MUL_R write-back depends on the configuration macro (see Configuration).
- Edge cases:
  - `in_vaild` outside IDLE is ignored and never queued.
  - D[EXP_W-1:0] == 0 gives plaint = 1.
  - cipht == 0 with a nonzero exponent gives plaint = 0.
- Reset, including mid-operation, takes effect on the next edge:
  - state = IDLE, so `ready`=1
  - `vaild`=0
  - plaint = 0
  - all datapath registers cleared
  - any in-flight result is discarded

## Timing
- Reset values: `ready`=1, `vaild`=0, plaint=32'd0.
- If accept occurs at edge k, `vaild` is high during the cycle after edge k+L, and `ready` returns the cycle after that.
- L with RSA_DEC_CONST_TIME_EN: 32 + 64·EXP_W.
- L without RSA_DEC_CONST_TIME_EN: 32 + 32·EXP_W + 32·popcount(D[EXP_W-1:0]).
- Minimum accept-to-accept period is L + 2 cycles.
- `plaint` changes only on the edge that enters DONE, or on reset.

## Configuration
- `RSA_DEC_CONST_TIME_EN` defined: MUL_R always runs its 32 cycles.
  - res is written back only when D[expidx]=1; otherwise the product is discarded.
  - Latency is independent of D, giving timing side-channel resistance.
- `RSA_DEC_CONST_TIME_EN` undefined: when D[expidx]=0, MUL_R is skipped entirely.
  - MUL_B follows directly.
  - Latency is data-dependent but shorter.

## Test plan
- With defaults (N=3233, D=2753, EXP_W=12):
  - cipht=2790 → plaint=65.
  - `vaild` pulse occurs 800 cycles after accept with the macro, 576 cycles without.
- cipht=6023 (2790+3233, ≥ N) → plaint=65; checks the REDUCE path.
- cipht=0 → plaint=0; cipht=1 → plaint=1; cipht=3232 → plaint=3232 (D is odd).
- Pulse `in_vaild` with cipht=100 every cycle during a decryption of 2790 → exactly one `vaild`, plaint=65, and `ready` low throughout.
- Assert `reset` for 1 cycle at accept+300 → next cycle shows `ready`=1, `vaild`=0, plaint=0, and no `vaild` ever follows. A new accept of 2790 then yields 65 with full latency L.
- Back-to-back: accept 2790 as soon as `ready` rises, then accept 1 on the first cycle `ready` is high again → plaint 65 then 1, with `vaild` pulses L+2 cycles apart.
